imm_extend: RTL and testbench

//   RV32I immediate generator for the decode stage of the pipelined core.

---
 rtl/imm_extend_if.sv | 26 ++
 rtl/imm_extend.sv | 50 +++++
 tb/tb_imm_extend.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imm_extend_if.sv
// Decode-stage immediate bus: instruction/format in, extended immediate and flags out.
interface imm_extend_if;
    logic [31:7] instr_i;
    logic [2:0]  imm_src_i;
    logic [31:0] imm_ext_o;
    logic [31:0] imm_ext_q_o;
    logic        imm_src_illegal_o;

    // Driver side: decode logic or testbench
    modport master (
        output instr_i,
        output imm_src_i,
        input  imm_ext_o,
        input  imm_ext_q_o,
        input  imm_src_illegal_o
    );

    // Immediate generator side
    modport slave (
        input  instr_i,
        input  imm_src_i,
        output imm_ext_o,
        output imm_ext_q_o,
        output imm_src_illegal_o
    );
endinterface

// File: rtl/imm_extend.sv
// RV32I immediate generator: combinational sign-extended immediate plus a
// registered copy and an illegal-format flag for pipeline/debug use.
module imm_extend (
    input  logic         clk_i,
    input  logic         reset_i,
    imm_extend_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] SRC_I   = 3'b000;
    localparam logic [2:0] SRC_S   = 3'b001;
    localparam logic [2:0] SRC_B   = 3'b010;
    localparam logic [2:0] SRC_J   = 3'b011;
    localparam logic [2:0] SRC_U   = 3'b100;

    logic [31:7]     instr;
    logic            sgn;
    logic [XLEN-1:0] imm_ext;
    logic            illegal_c;

    assign instr = bus.instr_i;
    assign sgn   = instr[31];

    // Format decode; unused selects yield zero so the output is never X
    always_comb begin
        imm_ext = '0;
        unique case (bus.imm_src_i)
            SRC_I:   imm_ext = {{20{sgn}}, instr[31:20]};
            SRC_S:   imm_ext = {{20{sgn}}, instr[31:25], instr[11:7]};
            SRC_B:   imm_ext = {{19{sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
            SRC_J:   imm_ext = {{11{sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
            SRC_U:   imm_ext = {instr[31:12], 12'b0};
            default: imm_ext = '0;
        endcase
    end

    assign illegal_c     = (bus.imm_src_i > SRC_U);
    assign bus.imm_ext_o = imm_ext;

    // Registered copy of the immediate and the illegal-select flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bus.imm_ext_q_o       <= '0;
            bus.imm_src_illegal_o <= 1'b0;
        end else begin
            bus.imm_ext_q_o       <= imm_ext;
            bus.imm_src_illegal_o <= illegal_c;
        end
    end
endmodule

// File: tb/tb_imm_extend.sv
// Directed bench for imm_extend: table of instruction words with hand-computed
// immediates, unused bits randomised, plus reset/capture sequences.
module tb_imm_extend;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    imm_extend_if bus ();

    imm_extend u_dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] word;
        logic [2:0]  src;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Instruction bits that carry immediate data for each format
    function automatic logic [31:0] used_bits(input logic [2:0] src);
        case (src)
            3'b000:  return 32'hFFF0_0000;
            3'b001:  return 32'hFE00_0F80;
            3'b010:  return 32'hFE00_0F80;
            3'b011:  return 32'hFFFF_F000;
            3'b100:  return 32'hFFFF_F000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic drive(input logic [31:0] word, input logic [2:0] src);
        logic [31:0] m32;
        logic [31:0] r32;
        m32 = used_bits(src);
        r32 = $urandom;
        bus.instr_i   = 25'((word[31:7] & m32[31:7]) | (r32[31:7] & ~m32[31:7]));
        bus.imm_src_i = src;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{32'h8000_0000, 3'b000, 32'hFFFF_F800};
        vecs[1]  = '{32'h7FF0_0000, 3'b000, 32'h0000_07FF};
        vecs[2]  = '{32'h0200_0200, 3'b001, 32'h0000_0024};
        vecs[3]  = '{32'h8200_0200, 3'b001, 32'hFFFF_F824};
        vecs[4]  = '{32'h8000_0000, 3'b010, 32'hFFFF_F000};
        vecs[5]  = '{32'h0000_0080, 3'b010, 32'h0000_0800};
        vecs[6]  = '{32'h7E00_0F80, 3'b010, 32'h0000_0FFE};
        vecs[7]  = '{32'h000F_F000, 3'b011, 32'h000F_F000};
        vecs[8]  = '{32'h0010_0000, 3'b011, 32'h0000_0800};
        vecs[9]  = '{32'h7FFF_F000, 3'b011, 32'h000F_FFFE};
        vecs[10] = '{32'h8000_0000, 3'b011, 32'hFFF0_0000};
        vecs[11] = '{32'hABCD_E000, 3'b100, 32'hABCD_E000};
        vecs[12] = '{32'h0000_1000, 3'b100, 32'h0000_1000};
        vecs[13] = '{32'hFFFF_FFFF, 3'b101, 32'h0000_0000};
        vecs[14] = '{32'hFFFF_FFFF, 3'b110, 32'h0000_0000};
        vecs[15] = '{32'hFFFF_FFFF, 3'b111, 32'h0000_0000};

        // Reset asserted from time zero: registers clear without a clock edge
        rst = 1'b1;
        drive(32'h8000_0000, 3'b000);
        #1;
        check32("reset_q_async", bus.imm_ext_q_o, 32'h0);
        check1("reset_ill_async", bus.imm_src_illegal_o, 1'b0);
        check32("comb_in_reset", bus.imm_ext_o, 32'hFFFF_F800);

        // Registers hold reset values across edges while reset stays high
        drive(32'hFFFF_FFFF, 3'b111);
        repeat (2) @(posedge clk);
        #1;
        check32("reset_hold_q", bus.imm_ext_q_o, 32'h0);
        check1("reset_hold_ill", bus.imm_src_illegal_o, 1'b0);

        // Release reset between edges; first capture at the next rising edge
        @(negedge clk);
        rst = 1'b0;
        drive(32'h8000_0000, 3'b000);
        #1;
        check32("post_release_q", bus.imm_ext_q_o, 32'h0);
        @(posedge clk);
        #1;
        check32("first_capture_q", bus.imm_ext_q_o, 32'hFFFF_F800);
        check1("first_capture_ill", bus.imm_src_illegal_o, 1'b0);

        // Table sweep, twice, with fresh random fill of don't-care bits each pass
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                drive(vecs[k].word, vecs[k].src);
                #1;
                check32($sformatf("comb_v%0d_r%0d", k, rep), bus.imm_ext_o, vecs[k].exp);
                check1($sformatf("known_v%0d_r%0d", k, rep), $isunknown(bus.imm_ext_o), 1'b0);
                @(posedge clk);
                #1;
                check32($sformatf("q_v%0d_r%0d", k, rep), bus.imm_ext_q_o, vecs[k].exp);
                check1($sformatf("ill_v%0d_r%0d", k, rep), bus.imm_src_illegal_o,
                       (vecs[k].src > 3'b100));
            end
        end

        // Mid-stream reset clears the immediate register at once; comb path unaffected
        @(negedge clk);
        drive(32'h8000_0000, 3'b000);
        @(posedge clk);
        #1;
        check32("pre_reset_q", bus.imm_ext_q_o, 32'hFFFF_F800);
        #2;
        rst = 1'b1;
        #1;
        check32("midreset_q", bus.imm_ext_q_o, 32'h0);
        check32("midreset_comb", bus.imm_ext_o, 32'hFFFF_F800);
        @(negedge clk);
        rst = 1'b0;

        // Mid-stream reset clears a set illegal flag at once
        drive(32'h1234_5678, 3'b110);
        @(posedge clk);
        #1;
        check1("pre_reset_ill", bus.imm_src_illegal_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("midreset_ill", bus.imm_src_illegal_o, 1'b0);
        check32("midreset_comb_ill", bus.imm_ext_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Comb output follows inputs during reset and tracks a change with no clock
        rst = 1'b1;
        drive(32'hABCD_E000, 3'b100);
        #1;
        check32("comb_follow_reset", bus.imm_ext_o, 32'hABCD_E000);
        check32("q_zero_reset", bus.imm_ext_q_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check32("capture_after_reset_u", bus.imm_ext_q_o, 32'hABCD_E000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
